writeback_unit: RTL

- Writeback stage feeding the register file's single write port and its two forwarding ports.
- Merges results from the functional unit (single-cycle, never stallable) and the data unit (variable latency, back-pressured through a small FIFO).
- Drives result_enable/result_addr/result to the register file, and result_addr_func/result_func and result_addr_data/result_data for operand forwarding.
- Keeps a 32-entry pending-write scoreboard used by issue logic to stall.

---
 rtl/writeback_unit.sv | 102 ++++++++++
 1 files changed

// File: rtl/writeback_unit.sv
// writeback_unit: merges functional-unit and data-unit results onto the register-file write port,
// with a small ordered data FIFO, forwarding ports and a pending-write scoreboard.
module writeback_unit #(
    parameter int DATA_FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        func_valid,
    input  logic [4:0]  func_addr,
    input  logic [31:0] func_result,
    input  logic        data_valid,
    output logic        data_ready,
    input  logic [4:0]  data_addr,
    input  logic [31:0] data_result,
    input  logic        issue_enable,
    input  logic [4:0]  issue_addr,
    output logic [31:0] busy,
    output logic        result_enable,
    output logic [4:0]  result_addr,
    output logic [31:0] result,
    output logic [4:0]  result_addr_func,
    output logic [31:0] result_func,
    output logic [4:0]  result_addr_data,
    output logic [31:0] result_data
);
    localparam int PW = DATA_FIFO_DEPTH > 1 ? $clog2(DATA_FIFO_DEPTH) : 1;
    localparam int CW = $clog2(DATA_FIFO_DEPTH + 1);

    logic [4:0]                 f_addr [DATA_FIFO_DEPTH];
    logic [31:0]                f_data [DATA_FIFO_DEPTH];
    logic [DATA_FIFO_DEPTH-1:0] f_live;
    logic [PW-1:0]              head, tail;
    logic [CW-1:0]              count;
    logic                       data_accept, data_discard, pop, bypass, push, head_live, wr_en;
    logic [4:0]                 wr_addr;
    logic [31:0]                wr_data, busy_next;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DATA_FIFO_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign data_ready   = count < CW'(DATA_FIFO_DEPTH);
    assign data_accept  = data_valid && data_ready;
    // Same-cycle data to the func destination is older in program order, so it is dead on arrival.
    assign data_discard = func_valid && func_addr != 5'd0 && func_addr == data_addr;
    assign pop          = !func_valid && count != '0;
    assign bypass       = !func_valid && count == '0 && data_accept;
    assign push         = data_accept && !data_discard && !bypass;
    assign head_live    = count != '0 && f_live[head];

    assign result_addr_func = result_addr;
    assign result_func      = result;
    assign result_addr_data = head_live ? f_addr[head] : 5'd0;
    assign result_data      = head_live ? f_data[head] : 32'd0;

    always_comb begin
        wr_en   = func_valid ? func_addr != 5'd0 : pop ? f_live[head] : bypass && data_addr != 5'd0;
        wr_addr = !wr_en ? 5'd0 : func_valid ? func_addr : pop ? f_addr[head] : data_addr;
        wr_data = !wr_en ? 32'd0 : func_valid ? func_result : pop ? f_data[head] : data_result;
        busy_next = busy;
        if (wr_en)
            busy_next[wr_addr] = 1'b0;
        if (issue_enable && issue_addr != 5'd0)
            busy_next[issue_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_enable <= 1'b0;
            result_addr   <= 5'd0;
            result        <= 32'd0;
            busy          <= 32'd0;
            f_live        <= '0;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            for (int i = 0; i < DATA_FIFO_DEPTH; i++) begin
                f_addr[i] <= 5'd0;
                f_data[i] <= 32'd0;
            end
        end else begin
            result_enable <= wr_en;
            result_addr   <= wr_addr;
            result        <= wr_data;
            busy          <= busy_next;
            for (int i = 0; i < DATA_FIFO_DEPTH; i++)
                if (func_valid && func_addr != 5'd0 && f_addr[i] == func_addr)
                    f_live[i] <= 1'b0;
            if (pop) begin
                f_live[head] <= 1'b0;
                head         <= nxt(head);
            end
            if (push) begin
                f_addr[tail] <= data_addr;
                f_data[tail] <= data_result;
                f_live[tail] <= data_addr != 5'd0;
                tail         <= nxt(tail);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule
